// File: rtl/seq_101x_symbol_tx.sv
// seq_101x_symbol_tx: sends each payload bit MSB first as a 1,0,1,d symbol for a 101x detector.
// Define SEQ_101X_TX_PARITY_EN to append a trailing 1,0,1,p even-parity symbol.
module seq_101x_symbol_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             x,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(WIDTH + 1);
`ifdef SEQ_101X_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SYM, PAR} state_t;
  logic p;
`else
  typedef enum logic [1:0] {IDLE, SYM} state_t;
`endif
  state_t         state;
  logic [WIDTH-1:0] sh;
  logic [1:0]     ph;
  logic [BW-1:0]  bc;
  assign ready = (state == IDLE);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      sh    <= '0;
      ph    <= '0;
      bc    <= '0;
      x     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SEQ_101X_TX_PARITY_EN
      p     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (valid) begin
          sh    <= data;
          ph    <= '0;
          bc    <= BW'(WIDTH - 1);
`ifdef SEQ_101X_TX_PARITY_EN
          p     <= ^data;
`endif
          state <= SYM;
          busy  <= 1'b1;
          x     <= 1'b1;
        end
        SYM: begin
          ph <= ph + 2'd1;
          case (ph)
            2'd0: x <= 1'b0;
            2'd1: x <= 1'b1;
            2'd2: begin
              x <= sh[WIDTH-1];
`ifndef SEQ_101X_TX_PARITY_EN
              done <= (bc == '0);
`endif
            end
            default: if (bc != '0) begin
              sh <= sh << 1;
              bc <= bc - 1'b1;
              x  <= 1'b1;
            end else begin
`ifdef SEQ_101X_TX_PARITY_EN
              state <= PAR;
              x     <= 1'b1;
`else
              state <= IDLE;
              x     <= 1'b0;
              busy  <= 1'b0;
`endif
            end
          endcase
        end
`ifdef SEQ_101X_TX_PARITY_EN
        PAR: begin
          ph   <= ph + 2'd1;
          x    <= (ph == 2'd0) ? 1'b0 : (ph == 2'd1) ? 1'b1 : (ph == 2'd2) ? p : 1'b0;
          done <= (ph == 2'd2);
          if (ph == 2'd3) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_seq_101x_symbol_tx.sv
// tb_seq_101x_symbol_tx: randomized and directed checks of the 101x symbol transmitter against a symbol-stream model.
module tb_seq_101x_symbol_tx;
  localparam int W = 8;
`ifdef SEQ_101X_TX_PARITY_EN
  localparam int L = 4 * (W + 1);
  localparam int NSYM = W + 1;
`else
  localparam int L = 4 * W;
  localparam int NSYM = W;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] data = '0;
  logic valid = 1'b0;
  logic ready, x, busy, done;
  int checks = 0;
  int errors = 0;
  bit xs[$];

  seq_101x_symbol_tx #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid),
    .ready(ready), .x(x), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Non-overlapping Mealy 101x detector over the captured line
  function automatic int zcount();
    int s = 0;
    int n = 0;
    foreach (xs[i]) begin
      if (s == 3) begin n++; s = 0; end
      else if (s == 2) s = xs[i] ? 3 : 0;
      else if (s == 1) s = xs[i] ? 1 : 2;
      else s = xs[i] ? 1 : 0;
    end
    return n;
  endfunction

  task automatic run_frame(input logic [W-1:0] d, input bit keep, input int poke, input logic [W-1:0] pdata);
    bit e[$];
    for (int b = W - 1; b >= 0; b--) begin
      e.push_back(1'b1); e.push_back(1'b0); e.push_back(1'b1); e.push_back(d[b]);
    end
`ifdef SEQ_101X_TX_PARITY_EN
    e.push_back(1'b1); e.push_back(1'b0); e.push_back(1'b1); e.push_back(^d);
`endif
    for (int t = 0; t < 200 && ready !== 1'b1; t++) begin @(posedge clk); #1; end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_wait: ready=%b want 1", ready); end
    data = d;
    valid = 1'b1;
    @(posedge clk); #1;
    if (!keep) valid = 1'b0;
    for (int i = 0; i < L; i++) begin
      checks++;
      if (x !== e[i] || busy !== 1'b1 || ready !== 1'b0 || done !== (i == L - 1)) begin
        errors++;
        $display("FAIL frame %h bit %0d: x=%b busy=%b ready=%b done=%b want x=%b busy=1 ready=0 done=%b",
                 d, i, x, busy, ready, done, e[i], (i == L - 1));
      end
      xs.push_back(x);
      if (i == poke) begin valid = 1'b1; data = pdata; end
      if (i == poke + 1 && !keep) valid = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (x !== 1'b0 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL frame %h gap: x=%b busy=%b ready=%b done=%b want 0 0 1 0", d, x, busy, ready, done);
    end
    xs.push_back(x);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    valid = 1'b1;
    data = 8'hA5;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (x !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
        errors++;
        $display("FAIL reset %0d: x=%b busy=%b done=%b ready=%b want 0 0 0 1", i, x, busy, done, ready);
      end
    end
    valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (x !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: x=%b busy=%b ready=%b want 0 0 1", x, busy, ready);
    end
  endtask

  task automatic test_single();
    xs.delete();
    run_frame(8'hA5, 1'b0, -1, '0);
    checks++;
    if (zcount() !== NSYM) begin errors++; $display("FAIL single_z: z=%0d want %0d", zcount(), NSYM); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    xs.delete();
    run_frame(8'hFF, 1'b1, 1, 8'h00);
    run_frame(8'h00, 1'b0, -1, '0);
    checks++;
    if (zcount() !== 2 * NSYM) begin errors++; $display("FAIL b2b_z: z=%0d want %0d", zcount(), 2 * NSYM); end
    checks++;
    if (xs.size() !== 2 * L + 2) begin errors++; $display("FAIL b2b_len: len=%0d want %0d", xs.size(), 2 * L + 2); end
  endtask

  task automatic test_ignore_midframe();
    run_frame(8'h96, 1'b0, 5, 8'h3C);
  endtask

  task automatic test_reset_midframe();
    @(posedge clk); #1;
    data = 8'h5A;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    checks++;
    if (x !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset: x=%b busy=%b done=%b ready=%b want 0 0 0 1", x, busy, done, ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (x !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL midreset_hold %0d: x=%b busy=%b done=%b want 0 0 0", i, x, busy, done);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    run_frame(8'h81, 1'b0, -1, '0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      for (int g = $urandom_range(0, 3); g > 0; g--) begin @(posedge clk); #1; end
      xs.delete();
      run_frame(d, 1'b0, -1, '0);
      checks++;
      if (zcount() !== NSYM) begin errors++; $display("FAIL random_z %h: z=%0d want %0d", d, zcount(), NSYM); end
    end
  endtask

`ifdef SEQ_101X_TX_PARITY_EN
  task automatic test_parity();
    run_frame(8'hA4, 1'b0, -1, '0);
    run_frame(8'hA5, 1'b0, -1, '0);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    test_random();
`ifdef SEQ_101X_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
